regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback arbiter that sits in front of the 32x32 RISC-V register file's single write port. It accepts results from two producers, the single-cycle ALU and the load/store unit (LSU), and serializes them onto the `wr`/`wr_data`/`wr_en` write port. ALU results are buffered in a small FIFO while the LSU holds the port. Writes that have been accepted but are not yet in the register file are exposed through two bypass lookups, so the read side never returns stale data.

## Interface
- `DEPTH`, 2: ALU queue entries (power of two, ≥2).
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `alu_valid` input 1: ALU result valid.
- `alu_ready` output 1: ALU result accepted this cycle when high with `alu_valid`.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `lsu_valid` input 1: load result valid.
- `lsu_ready` output 1: LSU handshake.
- `lsu_rd` input 5: load destination register.
- `lsu_data` input 32: load data.
- `wr` output 5: register file write address (registered).
- `wr_data` output 32: register file write data (registered).
- `wr_en` output 1: register file write enable (registered).
- `fwd_rs1`, `fwd_rs2` input 5 each: bypass lookup addresses.
- `fwd1_hit`, `fwd2_hit` output 1 each: a pending write to that register exists.
- `fwd1_data`, `fwd2_data` output 32 each: data of the matching pending write.
- `busy` output 1: queue non-empty or `wr_en` high.

## Operation
- The output stage (`wr`, `wr_data`, `wr_en`) is loaded every cycle. The register file always accepts, so the output stage never stalls.
- Fixed priority for the output stage each cycle, in order:
  1. Accepted LSU result with `lsu_rd != 0`.
  2. Queue head.
  3. Accepted ALU result when the queue is empty (direct path).
  4. Otherwise `wr_en` is 0. `wr` and `wr_data` hold their previous values.
- An ALU result that is accepted but does not win the output stage is enqueued at the tail.
- `lsu_ready` = 1 whenever not in reset. The LSU is never back-pressured.
- `alu_ready` = (count < DEPTH). It depends only on the registered count, with no combinational path from `lsu_valid`.
- Destination x0: a handshake with rd == 0 completes normally, but nothing is enqueued and `wr_en` is not asserted.
- Queue:
  - Head and tail pointers have log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits.
  - Enqueue and dequeue may happen in the same cycle; count is then unchanged.
- Ordering contract: issue logic never has two in-flight writes to the same rd. Under that contract, LSU-over-ALU reordering is architecturally invisible. The block does not check the contract.
- Bypass (combinational, per lookup):
  - Candidates are the valid queue entries plus the output stage when `wr_en` = 1.
  - The hit requires rd == lookup address, and the lookup address must not be 0.
  - If more than one candidate matches (contract violation), the newest queue entry wins, then older entries, then the output stage.
  - No hit: hit = 0 and data = 0.
  - In-flight inputs on `alu_*`/`lsu_*` are not bypassed.

## Timing
- Reset values:
  - `wr_en` = 0, `wr` = 0, `wr_data` = 0.
  - count = 0, pointers = 0.
  - `alu_ready` = 0 and `lsu_ready` = 0 while `rst_n` = 0.
  - `busy` = 0; `fwd*_hit` = 0.
- Latency:
  - LSU accepted in cycle N gives `wr_en` = 1 in N+1. The register file is updated at the end of N+1.
  - ALU accepted in cycle N with the queue empty and no LSU gives `wr_en` = 1 in N+1.
  - Otherwise the ALU write lands 1 cycle after it reaches the queue head and no LSU result competes.
- Throughput: one register file write per cycle.
  - Sustained LSU traffic starves the queue.
  - `alu_ready` falls the cycle after the queue fills.
- Reset asserted mid-operation: queued and output-stage writes are discarded immediately, with no write issued.

## Test plan
- **ALU direct write:** ALU x5 = 0xDEADBEEF in cycle 0, idle LSU. Required: `wr_en` = 1, `wr` = 5, `wr_data` = 0xDEADBEEF in cycle 1 only.
- **Contention:** ALU x1 = 0x11 and LSU x2 = 0x22 both in cycle 0. Required:
  - cycle 1 writes x2 = 0x22;
  - cycle 2 writes x1 = 0x11;
  - `fwd_rs1` = 1 in cycle 1 gives hit with 0x11.
- **Queue full:** LSU valid in cycles 0–3 (x10–x13) while ALU offers x20, x21, x22 from cycle 0. Required:
  - x20 and x21 are accepted;
  - `alu_ready` = 0 from cycle 2 to cycle 4;
  - write order x10–x13, then x20, x21, then x22.
- **x0 writes:** ALU rd = 0 and LSU rd = 0 with data 0xFFFFFFFF. Required: both handshakes complete, `wr_en` stays 0, `busy` stays 0.
- **Bypass:** x7 = 0xCAFE held in the output stage. Required: `fwd_rs2` = 7 gives `fwd2_hit` = 1 and `fwd2_data` = 0xCAFE; `fwd_rs2` = 0 gives hit = 0.
- **Reset mid-operation:** 2 ALU entries queued plus an output-stage write, then `rst_n` pulled low asynchronously mid-cycle. Required:
  - `wr_en`, `busy` and `alu_ready` drop immediately;
  - after release, no stale write is issued and `alu_ready` = 1.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Writeback arbiter bus: ALU and LSU result handshakes, register file write
// port, bypass lookups and the busy flag. The master drives producer results
// and lookup addresses; the slave is the arbiter itself.
interface regfile_writeback_if;
    // ALU producer
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    // Load/store unit producer
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;

    // Register file write port
    logic [4:0]  wr;
    logic [31:0] wr_data;
    logic        wr_en;

    // Bypass lookups
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    // Status
    logic        busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output fwd_rs1, fwd_rs2,
        input  alu_ready, lsu_ready,
        input  wr, wr_data, wr_en,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        input  busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  fwd_rs1, fwd_rs2,
        output alu_ready, lsu_ready,
        output wr, wr_data, wr_en,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        output busy
    );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback arbiter in front of the single register file write port.
// LSU results always win the registered output stage; ALU results go direct
// when nothing else is pending, otherwise they wait in a small FIFO. Pending
// writes (queue entries and the output stage) are visible to two bypass
// lookups so reads never see stale register file contents.
module regfile_writeback #(
    parameter int unsigned DEPTH = 2
) (
    input logic           clk,
    input logic           rst_n,
    regfile_writeback_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Queue state
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];

    // Output stage
    logic          wr_en_q;
    logic [4:0]    wr_q;
    logic [31:0]   wr_data_q;

    // Handshake and arbitration terms
    logic          alu_rdy;
    logic          lsu_rdy;
    logic          alu_acc;
    logic          lsu_acc;
    logic          alu_live;
    logic          lsu_win;
    logic          q_empty;

    // Next output stage and queue control
    logic          sel_en;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic          enq;
    logic          deq;

    // Queue slots ordered oldest (0) to newest, for the bypass search
    logic [PW-1:0] slot_idx [DEPTH];
    logic          slot_vld [DEPTH];

    // alu_ready depends only on registered count, gated off during reset
    assign alu_rdy  = rst_n && (count < FULL);
    assign lsu_rdy  = rst_n;
    assign alu_acc  = bus.alu_valid && alu_rdy;
    assign lsu_acc  = bus.lsu_valid && lsu_rdy;
    assign alu_live = alu_acc && (bus.alu_rd != '0);
    assign lsu_win  = lsu_acc && (bus.lsu_rd != '0);
    assign q_empty  = (count == '0);

    // Output stage priority: LSU, then queue head, then direct ALU path
    always_comb begin
        sel_en   = 1'b0;
        sel_rd   = wr_q;
        sel_data = wr_data_q;
        enq      = 1'b0;
        deq      = 1'b0;
        if (lsu_win) begin
            sel_en   = 1'b1;
            sel_rd   = bus.lsu_rd;
            sel_data = bus.lsu_data;
            enq      = alu_live;
        end else if (!q_empty) begin
            sel_en   = 1'b1;
            sel_rd   = q_rd[head];
            sel_data = q_data[head];
            deq      = 1'b1;
            enq      = alu_live;
        end else if (alu_live) begin
            sel_en   = 1'b1;
            sel_rd   = bus.alu_rd;
            sel_data = bus.alu_data;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                head <= head + PW'(1);
            end
            if (enq) begin
                tail <= tail + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail]   <= bus.alu_rd;
            q_data[tail] <= bus.alu_data;
        end
    end

    // Registered write port; address and data hold when no write is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_q      <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= sel_en;
            wr_q      <= sel_rd;
            wr_data_q <= sel_data;
        end
    end

    // Map queue age order onto storage slots for the bypass search
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_idx[i] = head + PW'(i);
            slot_vld[i] = (CW'(i) < count);
        end
    end

    // One bypass lookup per read port; later matches override earlier ones,
    // so the search order output stage -> oldest -> newest gives newest-wins
    for (genvar g = 0; g < 2; g++) begin : lk
        logic [4:0]  addr;
        logic        hit;
        logic [31:0] data;

        assign addr = (g == 0) ? bus.fwd_rs1 : bus.fwd_rs2;

        // Search pending writes for a match on this lookup address
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (addr != '0) begin
                if (wr_en_q && (wr_q == addr)) begin
                    hit  = 1'b1;
                    data = wr_data_q;
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (slot_vld[i] && (q_rd[slot_idx[i]] == addr)) begin
                        hit  = 1'b1;
                        data = q_data[slot_idx[i]];
                    end
                end
            end
        end
    end

    assign bus.alu_ready = alu_rdy;
    assign bus.lsu_ready = lsu_rdy;
    assign bus.wr        = wr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.fwd1_hit  = lk[0].hit;
    assign bus.fwd1_data = lk[0].data;
    assign bus.fwd2_hit  = lk[1].hit;
    assign bus.fwd2_data = lk[1].data;
    assign bus.busy      = (count != '0) || wr_en_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback. Expected register file writes are
// pushed to a scoreboard as stimulus is driven and popped by a monitor on
// every issued write; cycle-specific outputs are checked inline.
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_writeback_if bus ();

    regfile_writeback #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb [$];

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.fwd_rs1   = '0;
        bus.fwd_rs2   = '0;
    endtask

    // Advance to the drive point 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        sb.push_back({rd, data});
    endtask

    // Every issued write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_write: observed wr=%0d data=%h expected no write",
                       bus.wr, bus.wr_data);
            end
            if (sb.size() != 0) begin
                check("write_order", {bus.wr, bus.wr_data}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic acc;

        idle();

        // Reset state
        #12;
        check("rst_wr_en",     37'(bus.wr_en),     37'(0));
        check("rst_wr",        37'(bus.wr),        37'(0));
        check("rst_wr_data",   37'(bus.wr_data),   37'(0));
        check("rst_busy",      37'(bus.busy),      37'(0));
        check("rst_alu_ready", 37'(bus.alu_ready), 37'(0));
        check("rst_lsu_ready", 37'(bus.lsu_ready), 37'(0));
        check("rst_fwd1_hit",  37'(bus.fwd1_hit),  37'(0));
        check("rst_fwd2_hit",  37'(bus.fwd2_hit),  37'(0));
        rst_n = 1'b1;
        step();

        // ALU direct write: x5 = DEADBEEF in cycle 0, written in cycle 1 only
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        expect_write(5'd5, 32'hDEADBEEF);
        #3;
        check("direct_alu_ready", 37'(bus.alu_ready), 37'(1));
        step();
        idle();
        #3;
        check("direct_c1_wr_en",   37'(bus.wr_en),   37'(1));
        check("direct_c1_wr",      37'(bus.wr),      37'(5));
        check("direct_c1_wr_data", 37'(bus.wr_data), 37'(32'hDEADBEEF));
        step();
        #3;
        check("direct_c2_wr_en", 37'(bus.wr_en), 37'(0));
        step();

        // Contention: LSU x2 first, then ALU x1 from the queue
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'h11;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd2;
        bus.lsu_data  = 32'h22;
        expect_write(5'd2, 32'h22);
        expect_write(5'd1, 32'h11);
        step();
        idle();
        bus.fwd_rs1 = 5'd1;
        #3;
        check("cont_c1_wr",        37'(bus.wr),        37'(2));
        check("cont_c1_fwd1_hit",  37'(bus.fwd1_hit),  37'(1));
        check("cont_c1_fwd1_data", 37'(bus.fwd1_data), 37'(32'h11));
        step();
        bus.fwd_rs1 = 5'd0;
        #3;
        check("cont_c2_wr_en", 37'(bus.wr_en), 37'(1));
        check("cont_c2_wr",    37'(bus.wr),    37'(1));
        step();
        #3;
        check("cont_c3_busy", 37'(bus.busy), 37'(0));
        step();

        // Queue full: LSU x10..x13 in cycles 0-3, ALU offers x20..x22
        for (int i = 0; i < 4; i++) begin
            expect_write(5'(10 + i), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            expect_write(5'(20 + i), 32'h2000 + 32'(i));
        end
        k = 0;
        for (int c = 0; c < 8; c++) begin
            bus.lsu_valid = (c < 4);
            bus.lsu_rd    = 5'(10 + c);
            bus.lsu_data  = 32'h1000 + 32'(c);
            bus.alu_valid = (k < 3);
            bus.alu_rd    = 5'(20 + k);
            bus.alu_data  = 32'h2000 + 32'(k);
            #3;
            if (c <= 5) begin
                check($sformatf("full_alu_ready_c%0d", c), 37'(bus.alu_ready),
                      37'((c < 2 || c > 4) ? 1 : 0));
            end
            acc = bus.alu_valid && bus.alu_ready;
            step();
            if (acc) k++;
            if (c == 1) check("full_accepted_by_c1", 37'(k), 37'(2));
        end
        idle();
        check("full_all_accepted", 37'(k), 37'(3));
        for (int c = 0; c < 6 && (sb.size() != 0 || bus.busy); c++) step();
        check("full_drained", 37'(sb.size()), 37'(0));

        // x0 destinations: handshakes complete, nothing written
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFFFFFFFF;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'hFFFFFFFF;
        #3;
        check("x0_alu_ready", 37'(bus.alu_ready), 37'(1));
        check("x0_lsu_ready", 37'(bus.lsu_ready), 37'(1));
        step();
        idle();
        #3;
        check("x0_c1_wr_en", 37'(bus.wr_en), 37'(0));
        check("x0_c1_busy",  37'(bus.busy),  37'(0));
        step();
        #3;
        check("x0_c2_wr_en", 37'(bus.wr_en), 37'(0));
        check("x0_c2_busy",  37'(bus.busy),  37'(0));
        step();

        // Bypass from the output stage
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 32'hCAFE;
        expect_write(5'd7, 32'hCAFE);
        step();
        idle();
        bus.fwd_rs2 = 5'd7;
        bus.fwd_rs1 = 5'd8;
        #1;
        check("byp_fwd2_hit",  37'(bus.fwd2_hit),  37'(1));
        check("byp_fwd2_data", 37'(bus.fwd2_data), 37'(32'hCAFE));
        check("byp_fwd1_miss", 37'(bus.fwd1_hit),  37'(0));
        check("byp_fwd1_zero", 37'(bus.fwd1_data), 37'(0));
        bus.fwd_rs2 = 5'd0;
        #1;
        check("byp_x0_hit",  37'(bus.fwd2_hit),  37'(0));
        check("byp_x0_data", 37'(bus.fwd2_data), 37'(0));
        idle();
        step();
        step();

        // Reset mid-operation: two queued ALU writes plus x15 in the output stage
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd14;
        bus.lsu_data  = 32'h3000;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd24;
        bus.alu_data  = 32'h4000;
        expect_write(5'd14, 32'h3000);
        step();
        bus.lsu_rd    = 5'd15;
        bus.lsu_data  = 32'h3001;
        bus.alu_rd    = 5'd25;
        bus.alu_data  = 32'h4001;
        step();
        idle();
        bus.fwd_rs1 = 5'd24;
        #1;
        check("mid_wr",        37'(bus.wr),        37'(15));
        check("mid_wr_en",     37'(bus.wr_en),     37'(1));
        check("mid_alu_ready", 37'(bus.alu_ready), 37'(0));
        check("mid_fwd1_data", 37'(bus.fwd1_data), 37'(32'h4000));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en",     37'(bus.wr_en),     37'(0));
        check("arst_busy",      37'(bus.busy),      37'(0));
        check("arst_alu_ready", 37'(bus.alu_ready), 37'(0));
        check("arst_fwd1_hit",  37'(bus.fwd1_hit),  37'(0));
        #10;
        rst_n = 1'b1;
        idle();
        #1;
        check("post_rst_alu_ready", 37'(bus.alu_ready), 37'(1));
        for (int c = 0; c < 5; c++) step();
        check("post_rst_busy",  37'(bus.busy),  37'(0));
        check("post_rst_wr_en", 37'(bus.wr_en), 37'(0));

        check("scoreboard_empty", 37'(sb.size()), 37'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
